// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_BUSY = 1'b1
    } state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_M1   = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer holds the last winner
// and moves only when a grant is actually taken.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == OWN_M1) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance_i) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core load/store
// port and a secondary master, one access per grant.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          c_write_en,
    input  logic          c_read_en,
    output logic          c_exstall,
    output logic [DW-1:0] c_rdata,
    output logic          c_read_vd,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             owner_q;
    logic             owner_d;
    logic [DW-1:0]    c_rdata_q;
    logic [DW-1:0]    m1_rdata_q;

    logic       c_req;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       grant;
    logic       win;
    logic       sel_we;
    logic       ret;

    assign c_req = c_read_en | c_write_en;

    // No grants while a read is in flight or while reset is held.
    assign req = (state_q == ST_IDLE && rst) ? {m1_req, c_req} : 2'b00;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .advance_i (grant),
        .gnt_o     (gnt)
    );

    assign grant  = |gnt;
    assign win    = gnt[1];
    assign sel_we = win ? m1_we : c_write_en;
    assign ret    = (state_q == ST_RD_BUSY) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_CORE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (grant && !sel_we) begin
                    state_d = ST_RD_BUSY;
                    cnt_d   = CNT_LOAD;
                    owner_d = win;
                end
            end
            ST_RD_BUSY: begin
                if (ret) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        mem_en    = grant;
        mem_we    = grant & sel_we;
        mem_addr  = win ? m1_addr : c_addr;
        mem_wdata = win ? m1_wdata : c_wdata;
        m1_gnt    = gnt[1];
        c_read_vd = ret && (owner_q == OWN_CORE);
        m1_rvalid = ret && (owner_q == OWN_M1);
        c_rdata   = c_read_vd ? mem_rdata : c_rdata_q;
        m1_rdata  = m1_rvalid ? mem_rdata : m1_rdata_q;
        c_exstall = c_req && !(gnt[0] && c_write_en) && !c_read_vd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_rdata_q  <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (c_read_vd) begin
                c_rdata_q <= mem_rdata;
            end
            if (m1_rvalid) begin
                m1_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each with its own memory model and randomized traffic.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] c_addr     [2];
    logic [DW-1:0] c_wdata    [2];
    logic          c_write_en [2];
    logic          c_read_en  [2];
    logic          c_exstall  [2];
    logic [DW-1:0] c_rdata    [2];
    logic          c_read_vd  [2];
    logic          m1_req     [2];
    logic          m1_we      [2];
    logic [AW-1:0] m1_addr    [2];
    logic [DW-1:0] m1_wdata   [2];
    logic          m1_gnt     [2];
    logic [DW-1:0] m1_rdata   [2];
    logic          m1_rvalid  [2];
    logic          mem_en     [2];
    logic          mem_we     [2];
    logic [AW-1:0] mem_addr   [2];
    logic [DW-1:0] mem_wdata  [2];
    logic [DW-1:0] mem_rdata  [2];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_l1 (
        .clk(clk), .rst(rst),
        .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
        .c_write_en(c_write_en[0]), .c_read_en(c_read_en[0]),
        .c_exstall(c_exstall[0]), .c_rdata(c_rdata[0]),
        .c_read_vd(c_read_vd[0]),
        .m1_req(m1_req[0]), .m1_we(m1_we[0]),
        .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
        .m1_gnt(m1_gnt[0]), .m1_rdata(m1_rdata[0]),
        .m1_rvalid(m1_rvalid[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_l3 (
        .clk(clk), .rst(rst),
        .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
        .c_write_en(c_write_en[1]), .c_read_en(c_read_en[1]),
        .c_exstall(c_exstall[1]), .c_rdata(c_rdata[1]),
        .c_read_vd(c_read_vd[1]),
        .m1_req(m1_req[1]), .m1_we(m1_we[1]),
        .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
        .m1_gnt(m1_gnt[1]), .m1_rdata(m1_rdata[1]),
        .m1_rvalid(m1_rvalid[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 32'h5A5A0000 ^ {a[15:0], a[15:0]};
    endfunction

    // Memory model: words at addr[9:2], read data delayed by a shift pipe.
    logic [DW-1:0] mem_arr [2][256];
    bit            written [2][256];
    logic [DW-1:0] pipe    [2][4];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_en[d] === 1'b1) begin
                if (mem_we[d] === 1'b1) begin
                    mem_arr[d][mem_addr[d][9:2]] <= mem_wdata[d];
                    written[d][mem_addr[d][9:2]] <= 1'b1;
                end else begin
                    pipe[d][0] <= written[d][mem_addr[d][9:2]] ?
                        mem_arr[d][mem_addr[d][9:2]] : init_val(mem_addr[d]);
                end
            end
            for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
        end
    end

    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            c_addr[d] = '0; c_wdata[d] = '0;
            c_write_en[d] = 1'b0; c_read_en[d] = 1'b0;
            m1_req[d] = 1'b0; m1_we[d] = 1'b0;
            m1_addr[d] = '0; m1_wdata[d] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        m1_req[0] = 1'b1; m1_req[1] = 1'b1;
        m1_we[0] = 1'b1; m1_we[1] = 1'b1;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++; if (mem_en[d] !== 1'b0) begin bad++; $display("FAIL rst_mem_en[%0d]: got %b want 0", d, mem_en[d]); end
            total++; if (mem_we[d] !== 1'b0) begin bad++; $display("FAIL rst_mem_we[%0d]: got %b want 0", d, mem_we[d]); end
            total++; if (m1_gnt[d] !== 1'b0) begin bad++; $display("FAIL rst_m1_gnt[%0d]: got %b want 0", d, m1_gnt[d]); end
            total++; if (c_read_vd[d] !== 1'b0) begin bad++; $display("FAIL rst_c_read_vd[%0d]: got %b want 0", d, c_read_vd[d]); end
            total++; if (m1_rvalid[d] !== 1'b0) begin bad++; $display("FAIL rst_m1_rvalid[%0d]: got %b want 0", d, m1_rvalid[d]); end
            total++; if (c_rdata[d] !== '0) begin bad++; $display("FAIL rst_c_rdata[%0d]: got %h want 0", d, c_rdata[d]); end
            total++; if (m1_rdata[d] !== '0) begin bad++; $display("FAIL rst_m1_rdata[%0d]: got %h want 0", d, m1_rdata[d]); end
            total++; if (c_exstall[d] !== 1'b0) begin bad++; $display("FAIL rst_c_exstall[%0d]: got %b want 0", d, c_exstall[d]); end
        end
        step();
        clear_inputs();
        rst = 1'b1;
        step();
    endtask

    task automatic test_random(input int d, input int ncyc);
        logic [DW-1:0] rm [int];
        int L;
        int c_st, c_wr, c_wait;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd, cexp;
        int m_st, m_wr, m_wait, m_lat;
        logic [AW-1:0] ma;
        logic [DW-1:0] md, mexp;
        int cyc;
        L = (d == 0) ? 1 : 3;
        c_st = 0; c_wr = 0; c_wait = 0; ca = '0; cd = '0;
        m_st = 0; m_wr = 0; m_wait = 0; m_lat = 0; ma = '0; md = '0;
        mexp = '0;
        cyc = 0;
        while ((cyc < ncyc || c_st != 0 || m_st != 0) && cyc < ncyc + 60) begin
            if (c_st == 0 && cyc < ncyc && $urandom_range(0, 2) == 0) begin
                c_wr = int'($urandom_range(0, 1));
                ca = {22'd0, 8'($urandom_range(0, 127)), 2'b00};
                cd = $urandom;
                c_addr[d] = ca; c_wdata[d] = cd;
                c_write_en[d] = (c_wr == 1);
                c_read_en[d] = (c_wr == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                c_st = 1; c_wait = 0;
            end else if (c_st == 0) begin
                c_write_en[d] = 1'b0; c_read_en[d] = 1'b0;
            end
            if (m_st == 0 && cyc < ncyc && $urandom_range(0, 2) == 0) begin
                m_wr = int'($urandom_range(0, 1));
                ma = {22'd0, 8'($urandom_range(128, 255)), 2'b00};
                md = $urandom;
                m1_req[d] = 1'b1; m1_we[d] = (m_wr == 1);
                m1_addr[d] = ma; m1_wdata[d] = md;
                m_st = 1; m_wait = 0;
            end else if (m_st != 1) begin
                m1_req[d] = 1'b0;
            end
            settle();
            if (c_st == 1) begin
                c_wait++;
                if (c_wr == 1) begin
                    if (c_exstall[d] === 1'b0) begin
                        total++;
                        if ({mem_en[d], mem_we[d], m1_gnt[d], mem_addr[d], mem_wdata[d]} !== {3'b110, ca, cd}) begin
                            bad++; $display("FAIL rnd_core_wr[%0d]: got en=%b we=%b g1=%b a=%h w=%h want 1 1 0 %h %h",
                                d, mem_en[d], mem_we[d], m1_gnt[d], mem_addr[d], mem_wdata[d], ca, cd);
                        end
                        rm[int'(ca >> 2)] = cd;
                        c_st = 0;
                    end
                end else if (c_read_vd[d] === 1'b1) begin
                    cexp = rm.exists(int'(ca >> 2)) ? rm[int'(ca >> 2)] : init_val(ca);
                    total++;
                    if (c_rdata[d] !== cexp || c_exstall[d] !== 1'b0) begin
                        bad++; $display("FAIL rnd_core_rd[%0d]: got data=%h stall=%b want %h 0", d, c_rdata[d], c_exstall[d], cexp);
                    end
                    c_st = 0;
                end else begin
                    total++;
                    if (c_exstall[d] !== 1'b1) begin bad++; $display("FAIL rnd_core_rd_stall[%0d]: got %b want 1", d, c_exstall[d]); end
                end
                if (c_st == 1 && c_wait > 20) begin
                    total++; bad++; $display("FAIL rnd_core_timeout[%0d]: got no completion want completion within 20", d);
                    c_st = 0;
                end
            end else begin
                total++;
                if (c_read_vd[d] !== 1'b0 || c_exstall[d] !== 1'b0) begin
                    bad++; $display("FAIL rnd_core_idle[%0d]: got vd=%b stall=%b want 0 0", d, c_read_vd[d], c_exstall[d]);
                end
            end
            if (m_st == 1) begin
                m_wait++;
                if (m1_gnt[d] === 1'b1) begin
                    total++;
                    if ({mem_en[d], mem_we[d], mem_addr[d]} !== {1'b1, (m_wr == 1), ma} || (m_wr == 1 && mem_wdata[d] !== md)) begin
                        bad++; $display("FAIL rnd_m1_gnt[%0d]: got en=%b we=%b a=%h w=%h want 1 %0d %h %h",
                            d, mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], m_wr, ma, md);
                    end
                    if (m_wr == 1) begin
                        rm[int'(ma >> 2)] = md;
                        m_st = 0;
                    end else begin
                        mexp = rm.exists(int'(ma >> 2)) ? rm[int'(ma >> 2)] : init_val(ma);
                        m_st = 2; m_lat = 0;
                    end
                end else if (m_wait > 20) begin
                    total++; bad++; $display("FAIL rnd_m1_timeout[%0d]: got no grant want grant within 20", d);
                    m_st = 0;
                end
            end else if (m_st == 2) begin
                m_lat++;
                if (m1_rvalid[d] === 1'b1) begin
                    total++;
                    if (m_lat != L || m1_rdata[d] !== mexp) begin
                        bad++; $display("FAIL rnd_m1_rd[%0d]: got lat=%0d data=%h want %0d %h", d, m_lat, m1_rdata[d], L, mexp);
                    end
                    m_st = 0;
                end else if (m_lat > L) begin
                    total++; bad++; $display("FAIL rnd_m1_rvalid[%0d]: got none want pulse at %0d", d, L);
                    m_st = 0;
                end
            end else begin
                total++;
                if (m1_rvalid[d] !== 1'b0 || m1_gnt[d] !== 1'b0) begin
                    bad++; $display("FAIL rnd_m1_idle[%0d]: got rv=%b g=%b want 0 0", d, m1_rvalid[d], m1_gnt[d]);
                end
            end
            step();
            if (c_st == 0) begin c_write_en[d] = 1'b0; c_read_en[d] = 1'b0; end
            cyc++;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_core_write();
        c_write_en[0] = 1'b1; c_addr[0] = 32'h80; c_wdata[0] = 32'h12345678;
        settle();
        total++; if ({mem_en[0], mem_we[0]} !== 2'b11) begin bad++; $display("FAIL cw_en_we: got %b%b want 11", mem_en[0], mem_we[0]); end
        total++; if (mem_addr[0] !== 32'h80 || mem_wdata[0] !== 32'h12345678) begin bad++; $display("FAIL cw_addr_data: got %h %h want 80 12345678", mem_addr[0], mem_wdata[0]); end
        total++; if (c_exstall[0] !== 1'b0) begin bad++; $display("FAIL cw_stall: got %b want 0", c_exstall[0]); end
        step();
        c_addr[0] = 32'h40; c_wdata[0] = 32'hDEADBEEF;
        settle();
        total++; if (c_exstall[0] !== 1'b0) begin bad++; $display("FAIL cw2_stall: got %b want 0", c_exstall[0]); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_core_read_lat1();
        c_read_en[0] = 1'b1; c_addr[0] = 32'h40;
        settle();
        total++; if ({mem_en[0], mem_we[0]} !== 2'b10 || mem_addr[0] !== 32'h40) begin bad++; $display("FAIL cr_grant: got en=%b we=%b a=%h want 1 0 40", mem_en[0], mem_we[0], mem_addr[0]); end
        total++; if (c_exstall[0] !== 1'b1 || c_read_vd[0] !== 1'b0) begin bad++; $display("FAIL cr_grant_stall: got stall=%b vd=%b want 1 0", c_exstall[0], c_read_vd[0]); end
        step();
        settle();
        total++; if (c_read_vd[0] !== 1'b1 || c_rdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL cr_return: got vd=%b d=%h want 1 deadbeef", c_read_vd[0], c_rdata[0]); end
        total++; if (c_exstall[0] !== 1'b0 || mem_en[0] !== 1'b0) begin bad++; $display("FAIL cr_return_stall: got stall=%b en=%b want 0 0", c_exstall[0], mem_en[0]); end
        step();
        clear_inputs();
        settle();
        total++; if (c_read_vd[0] !== 1'b0 || c_rdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL cr_hold: got vd=%b d=%h want 0 deadbeef", c_read_vd[0], c_rdata[0]); end
        step();
    endtask

    task automatic test_first_tie();
        clear_inputs();
        rst = 1'b0;
        step();
        c_read_en[0] = 1'b1; c_addr[0] = 32'h80;
        m1_req[0] = 1'b1; m1_we[0] = 1'b1; m1_addr[0] = 32'h200; m1_wdata[0] = 32'hCAFE0001;
        rst = 1'b1;
        settle();
        total++; if (m1_gnt[0] !== 1'b0 || mem_addr[0] !== 32'h80 || mem_we[0] !== 1'b0) begin bad++; $display("FAIL tie_core_first: got g1=%b a=%h we=%b want 0 80 0", m1_gnt[0], mem_addr[0], mem_we[0]); end
        total++; if (c_exstall[0] !== 1'b1) begin bad++; $display("FAIL tie_stall: got %b want 1", c_exstall[0]); end
        step();
        settle();
        total++; if (m1_gnt[0] !== 1'b0 || c_read_vd[0] !== 1'b1 || c_rdata[0] !== 32'h12345678) begin bad++; $display("FAIL tie_return: got g1=%b vd=%b d=%h want 0 1 12345678", m1_gnt[0], c_read_vd[0], c_rdata[0]); end
        step();
        c_read_en[0] = 1'b0;
        settle();
        total++; if (m1_gnt[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== 32'h200) begin bad++; $display("FAIL tie_m1_next: got g1=%b we=%b a=%h want 1 1 200", m1_gnt[0], mem_we[0], mem_addr[0]); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        int nc;
        int nm;
        logic exp_m1;
        nc = 0; nm = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            c_write_en[0] = 1'b1; c_addr[0] = 32'h10 + 32'(4 * i); c_wdata[0] = 32'(i);
            m1_req[0] = 1'b1; m1_we[0] = 1'b1; m1_addr[0] = 32'h300 + 32'(4 * i); m1_wdata[0] = 32'(100 + i);
            exp_m1 = (i % 2) == 1;
            settle();
            total++;
            if (m1_gnt[0] !== exp_m1 || c_exstall[0] !== exp_m1 || mem_addr[0] !== (exp_m1 ? m1_addr[0] : c_addr[0])) begin
                bad++; $display("FAIL b2b_%0d: got g1=%b stall=%b a=%h want %b %b", i, m1_gnt[0], c_exstall[0], mem_addr[0], exp_m1, exp_m1);
            end
            if (m1_gnt[0] === 1'b1) nm++;
            if (c_exstall[0] === 1'b0) nc++;
            step();
        end
        total++; if (nc != 4 || nm != 4) begin bad++; $display("FAIL b2b_counts: got core=%0d m1=%0d want 4 4", nc, nm); end
        clear_inputs();
        step();
    endtask

    task automatic test_lat3();
        do_reset();
        m1_req[1] = 1'b1; m1_we[1] = 1'b1; m1_addr[1] = 32'h100; m1_wdata[1] = 32'h0BADF00D;
        settle();
        total++; if (m1_gnt[1] !== 1'b1 || mem_we[1] !== 1'b1) begin bad++; $display("FAIL l3_wr: got g1=%b we=%b want 1 1", m1_gnt[1], mem_we[1]); end
        step();
        m1_we[1] = 1'b0;
        settle();
        total++; if (m1_gnt[1] !== 1'b1 || mem_en[1] !== 1'b1 || mem_we[1] !== 1'b0) begin bad++; $display("FAIL l3_rd_gnt: got g1=%b en=%b we=%b want 1 1 0", m1_gnt[1], mem_en[1], mem_we[1]); end
        step();
        m1_req[1] = 1'b0;
        c_write_en[1] = 1'b1; c_addr[1] = 32'h84; c_wdata[1] = 32'h55AA55AA;
        for (int k = 1; k <= 3; k++) begin
            settle();
            total++;
            if (k < 3 && (c_exstall[1] !== 1'b1 || m1_rvalid[1] !== 1'b0 || mem_en[1] !== 1'b0)) begin
                bad++; $display("FAIL l3_busy_%0d: got stall=%b rv=%b en=%b want 1 0 0", k, c_exstall[1], m1_rvalid[1], mem_en[1]);
            end
            if (k == 3 && (m1_rvalid[1] !== 1'b1 || m1_rdata[1] !== 32'h0BADF00D || c_exstall[1] !== 1'b1)) begin
                bad++; $display("FAIL l3_return: got rv=%b d=%h stall=%b want 1 0badf00d 1", m1_rvalid[1], m1_rdata[1], c_exstall[1]);
            end
            step();
        end
        settle();
        total++; if (c_exstall[1] !== 1'b0 || {mem_en[1], mem_we[1]} !== 2'b11 || mem_addr[1] !== 32'h84 || m1_rvalid[1] !== 1'b0) begin
            bad++; $display("FAIL l3_idle_write: got stall=%b en=%b we=%b a=%h rv=%b want 0 1 1 84 0", c_exstall[1], mem_en[1], mem_we[1], mem_addr[1], m1_rvalid[1]);
        end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_reset_midread();
        int spurious;
        spurious = 0;
        m1_req[1] = 1'b1; m1_we[1] = 1'b0; m1_addr[1] = 32'h100;
        settle();
        total++; if (m1_gnt[1] !== 1'b1) begin bad++; $display("FAIL mr_gnt: got %b want 1", m1_gnt[1]); end
        step();
        clear_inputs();
        rst = 1'b0;
        #1;
        total++;
        if ({mem_en[1], mem_we[1], m1_gnt[1], m1_rvalid[1], c_read_vd[1]} !== 5'b0 || m1_rdata[1] !== '0 || c_rdata[1] !== '0) begin
            bad++; $display("FAIL mr_outputs: got en=%b we=%b g=%b rv=%b vd=%b md=%h cd=%h want all 0",
                mem_en[1], mem_we[1], m1_gnt[1], m1_rvalid[1], c_read_vd[1], m1_rdata[1], c_rdata[1]);
        end
        step();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (m1_rvalid[1] !== 1'b0 || c_read_vd[1] !== 1'b0) spurious++;
            step();
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL mr_no_valid: got %0d pulses want 0", spurious); end
        c_write_en[1] = 1'b1; c_addr[1] = 32'h88; c_wdata[1] = 32'h1;
        m1_req[1] = 1'b1; m1_we[1] = 1'b1; m1_addr[1] = 32'h208; m1_wdata[1] = 32'h2;
        settle();
        total++; if (m1_gnt[1] !== 1'b0 || c_exstall[1] !== 1'b0) begin bad++; $display("FAIL mr_tie: got g1=%b stall=%b want 0 0", m1_gnt[1], c_exstall[1]); end
        step();
        clear_inputs();
        step();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        step();
        test_reset();
        test_random(0, 300);
        test_random(1, 300);
        test_core_write();
        test_core_read_lat1();
        test_first_tie();
        test_back_to_back();
        test_lat3();
        test_reset_midread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want end before 200000");
        $fatal(1, "watchdog");
    end

endmodule
